mc_decoder: RTL and testbench

- Multicycle successor to the single-cycle instruction decoder.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over 3-5 cycles, so one ALU and one memory are shared across cycles.
- Adds conditional execution through an internal NZCV flags register, a parametrised ALU-control width with extra data-processing ops (EOR, MOV, CMP, TST), and illegal-instruction reporting.
- Sits between the instruction register and the multicycle datapath.

---
 rtl/mc_decoder_if.sv | 37 +++
 rtl/mc_decoder.sv | 191 +++++++++++++++++++
 tb/tb_mc_decoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_decoder_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle decoder.
// The slave modport is the decoder; the master modport is the instruction register/datapath side.
interface mc_decoder_if #(
  parameter int ALUCTRL_W = 3
);
  logic [3:0]           Cond;
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 MemWrite;
  logic                 RegWrite;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           Flags;
  logic                 Illegal;
  logic [3:0]           State;

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
    output ImmSrc, RegSrc, ALUControl, Flags, Illegal, State
  );

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
    input  ImmSrc, RegSrc, ALUControl, Flags, Illegal, State
  );
endinterface

// File: rtl/mc_decoder.sv
// Multicycle Moore control unit: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flags and the latched condition result, and reports illegal opcodes.
module mc_decoder #(
  parameter int ALUCTRL_W = 3,
  parameter bit COND_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mc_decoder_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  localparam bit EXT_OPS = (ALUCTRL_W > 2);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic       dp_legal, dp_nowrite, dp_cv;
  logic [2:0] dp_alu;
  logic       pcw, memw, regw, irw, adr, ill;
  logic [1:0] rsrc, srca, srcb, imm_src, reg_src;
  logic [ALUCTRL_W-1:0] aluctl;

  function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = cy;
      4'b0011: cond_ex = ~cy;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = cy & ~z;
      4'b1001: cond_ex = ~cy | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  // Data-processing op table; dp_cv marks the arithmetic ops that own C and V.
  always_comb begin
    dp_legal   = 1'b0;
    dp_nowrite = 1'b0;
    dp_cv      = 1'b0;
    dp_alu     = 3'b000;
    case (bus.Funct[4:1])
      4'b0100: begin dp_legal = 1'b1; dp_alu = 3'b000; dp_cv = 1'b1; end
      4'b0010: begin dp_legal = 1'b1; dp_alu = 3'b001; dp_cv = 1'b1; end
      4'b0000: begin dp_legal = 1'b1; dp_alu = 3'b010; end
      4'b1100: begin dp_legal = 1'b1; dp_alu = 3'b011; end
      4'b0001: begin dp_legal = EXT_OPS; dp_alu = 3'b100; end
      4'b1101: begin dp_legal = EXT_OPS; dp_alu = 3'b101; end
      4'b1010: begin
        dp_legal = EXT_OPS & bus.Funct[0]; dp_alu = 3'b001; dp_nowrite = 1'b1; dp_cv = 1'b1;
      end
      4'b1000: begin
        dp_legal = EXT_OPS & bus.Funct[0]; dp_alu = 3'b010; dp_nowrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    reg_src = 2'b00;
    case (bus.Op)
      2'b01: begin imm_src = 2'b01; reg_src = bus.Funct[0] ? 2'b00 : 2'b10; end
      2'b10: begin imm_src = 2'b10; reg_src = 2'b01; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    condex_d = condex_q;
    pcw = 1'b0; memw = 1'b0; regw = 1'b0; irw = 1'b0; adr = 1'b0; ill = 1'b0;
    rsrc = 2'b00; srca = 2'b00; srcb = 2'b00;
    aluctl = '0;
    case (state_q)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1; srca = 2'b01; srcb = 2'b10; rsrc = 2'b10;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        srca = 2'b01; srcb = 2'b10; rsrc = 2'b10;
        condex_d = COND_EN ? cond_ex(bus.Cond, flags_q) : 1'b1;
        case (bus.Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = !dp_legal ? S_ILLEGAL : (bus.Funct[5] ? S_EXECI : S_EXECR);
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        srcb = 2'b01;
        state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rsrc = 2'b01;
        regw = condex_q;
        pcw  = condex_q & (bus.Rd == 4'hF);
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        adr  = 1'b1;
        memw = condex_q;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        srcb   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        aluctl = ALUCTRL_W'(dp_alu);
        // Flags are captured on the edge that leaves EXEC, only for S-suffixed, condition-passed ops.
        if (condex_q && bus.Funct[0]) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (dp_cv) flags_d[1:0] = bus.ALUFlags[1:0];
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regw = condex_q & ~dp_nowrite;
        pcw  = condex_q & ~dp_nowrite & (bus.Rd == 4'hF);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca = 2'b10; srcb = 2'b01; rsrc = 2'b10;
        pcw  = condex_q;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        ill = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every write strobe combinationally so nothing fires while it is held.
  assign bus.PCWrite    = pcw  & ~reset;
  assign bus.MemWrite   = memw & ~reset;
  assign bus.RegWrite   = regw & ~reset;
  assign bus.IRWrite    = irw  & ~reset;
  assign bus.Illegal    = ill  & ~reset;
  assign bus.AdrSrc     = adr;
  assign bus.ResultSrc  = rsrc;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegSrc     = reg_src;
  assign bus.ALUControl = aluctl;
  assign bus.Flags      = flags_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_mc_decoder.sv
// Directed bench for mc_decoder: a per-cycle vector table over an instruction program,
// plus hand sequences for reset during MEMWR and the two-bit ALU-control variant.
module tb_mc_decoder;

  logic clk;
  logic reset;

  mc_decoder_if #(.ALUCTRL_W(3)) bus ();
  mc_decoder_if #(.ALUCTRL_W(2)) bus2 ();

  mc_decoder #(.ALUCTRL_W(3), .COND_EN(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mc_decoder #(.ALUCTRL_W(2), .COND_EN(1'b1)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  // exp = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
  //        ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags, Illegal}
  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  af;
    logic [26:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [26:0] exp_q[$];

  logic [3:0] cur_cond, cur_rd, cur_af;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic ins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] r, input logic [3:0] a);
    cur_cond = c; cur_op = o; cur_funct = f; cur_rd = r; cur_af = a;
  endtask

  task automatic add(input logic [3:0] st, input logic [3:0] wen, input logic adr,
                     input logic [1:0] rsrc, input logic [1:0] srca, input logic [1:0] srcb,
                     input logic [1:0] imm, input logic [1:0] rs, input logic [2:0] alu,
                     input logic [3:0] fl, input logic ill);
    vec_t v;
    v.cond = cur_cond; v.op = cur_op; v.funct = cur_funct; v.rd = cur_rd; v.af = cur_af;
    v.exp = {st, wen, adr, rsrc, srca, srcb, imm, rs, alu, fl, ill};
    tbl.push_back(v);
  endtask

  task automatic add_fd(input logic [1:0] imm, input logic [1:0] rs, input logic [3:0] fl);
    add(4'd0, 4'b1001, 1'b0, 2'b10, 2'b01, 2'b10, imm, rs, 3'd0, fl, 1'b0);
    add(4'd1, 4'b0000, 1'b0, 2'b10, 2'b01, 2'b10, imm, rs, 3'd0, fl, 1'b0);
  endtask

  // ---------------- driver / checker ----------------
  task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] a);
    bus.Cond = c; bus.Op = o; bus.Funct = f; bus.Rd = r; bus.ALUFlags = a;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [26:0] pack_out();
    return {bus.State, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
            bus.ALUControl, bus.Flags, bus.Illegal};
  endfunction

  // ---------------- program ----------------
  task automatic build_table();
    // ADDS R1,R2,#5 with ALUFlags 0110
    ins(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110);
    add_fd(2'b00, 2'b00, 4'b0000);
    add(4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'd0, 4'b0000, 1'b0);
    add(4'd8, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0110, 1'b0);
    // CMP, ALUFlags 0100 -> Z set, no register write
    ins(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    add_fd(2'b00, 2'b00, 4'b0110);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 4'b0110, 1'b0);
    add(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    // BEQ taken
    ins(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    add_fd(2'b10, 2'b01, 4'b0100);
    add(4'd9, 4'b1000, 1'b0, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 3'd0, 4'b0100, 1'b0);
    // CMP, ALUFlags 0000 -> Z clear; BEQ not taken
    ins(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0000);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 4'b0100, 1'b0);
    add(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0000, 1'b0);
    ins(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    add_fd(2'b10, 2'b01, 4'b0000);
    add(4'd9, 4'b0000, 1'b0, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 3'd0, 4'b0000, 1'b0);
    // LDR R3 and LDR PC
    for (int k = 0; k < 2; k++) begin
      ins(4'hE, 2'b01, 6'b011001, (k == 0) ? 4'd3 : 4'hF, 4'b0000);
      add_fd(2'b01, 2'b00, 4'b0000);
      add(4'd2, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 3'd0, 4'b0000, 1'b0);
      add(4'd3, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'd0, 4'b0000, 1'b0);
      add(4'd4, (k == 0) ? 4'b0010 : 4'b1010, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00,
          3'd0, 4'b0000, 1'b0);
    end
    // CMP sets Z, then STRNE is suppressed
    ins(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    add_fd(2'b00, 2'b00, 4'b0000);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 4'b0000, 1'b0);
    add(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    ins(4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000);
    add_fd(2'b01, 2'b10, 4'b0100);
    add(4'd2, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 3'd0, 4'b0100, 1'b0);
    add(4'd5, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 3'd0, 4'b0100, 1'b0);
    // Op=11 -> ILLEGAL for one cycle
    ins(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd10, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b1);
    // ADDS with Cond=1111: walks EXECI/ALUWB, no write, no flag update
    ins(4'hF, 2'b00, 6'b101001, 4'd1, 4'b1111);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    add(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    // ADD PC,#imm (no S): PC writeback, flags untouched
    ins(4'hE, 2'b00, 6'b101000, 4'hF, 4'b1111);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    add(4'd8, 4'b1010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    // CMP without S, and an unassigned DP opcode: both illegal
    ins(4'hE, 2'b00, 6'b010100, 4'd0, 4'b0000);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd10, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b1);
    ins(4'hE, 2'b00, 6'b001100, 4'd0, 4'b0000);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd10, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b1);
    // MOVS (NZ only): ALUFlags 1011 -> flags 1000
    ins(4'hE, 2'b00, 6'b011011, 4'd1, 4'b1011);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd5, 4'b0100, 1'b0);
    add(4'd8, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1000, 1'b0);
    // EORS #imm: ALUFlags 0111 -> flags 0100 (CV kept at 00)
    ins(4'hE, 2'b00, 6'b100011, 4'd1, 4'b0111);
    add_fd(2'b00, 2'b00, 4'b1000);
    add(4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'd4, 4'b1000, 1'b0);
    add(4'd8, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    // ORREQ passes (Z=1); ANDNE fails
    ins(4'h0, 2'b00, 6'b011000, 4'd1, 4'b0000);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd3, 4'b0100, 1'b0);
    add(4'd8, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    ins(4'h1, 2'b00, 6'b000000, 4'd1, 4'b0000);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2, 4'b0100, 1'b0);
    add(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0100, 1'b0);
    // TST: ALUFlags 1011 -> flags 1000, no write
    ins(4'hE, 2'b00, 6'b010001, 4'd1, 4'b1011);
    add_fd(2'b00, 2'b00, 4'b0100);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2, 4'b0100, 1'b0);
    add(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b1000, 1'b0);
    // SUBS: ALUFlags 0011 -> flags 0011
    ins(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0011);
    add_fd(2'b00, 2'b00, 4'b1000);
    add(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 4'b1000, 1'b0);
    add(4'd8, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 4'b0011, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    drive(4'hE, 2'b00, 6'b000000, 4'd0, 4'b0000);
    // EOR register form on the two-bit ALU-control instance
    bus2.Cond = 4'hE; bus2.Op = 2'b00; bus2.Funct = 6'b000010; bus2.Rd = 4'd1;
    bus2.ALUFlags = 4'b0000;
    build_table();
    foreach (tbl[i]) exp_q.push_back(tbl[i].exp);

    #1;
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_flags", 32'(bus.Flags), 32'd0);
    chk("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
    chk("rst_irwrite", 32'(bus.IRWrite), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_state", 32'(bus.State), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      logic [26:0] e;
      drive(tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].af);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_st%0d", i, e[26:23]), 32'(pack_out()), 32'(e));
      @(negedge clk);
    end

    // STR (AL) then reset while in MEMWR
    drive(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000);
    #1;
    chk("str_fetch_state", 32'(bus.State), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("memwr_state", 32'(bus.State), 32'd5);
    chk("memwr_memwrite", 32'(bus.MemWrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_mid_state", 32'(bus.State), 32'd0);
    chk("rst_mid_flags", 32'(bus.Flags), 32'd0);
    chk("rst_mid_pcwrite", 32'(bus.PCWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("w2_fetch_state", 32'(bus2.State), 32'd0);
    chk("w2_fetch_alu", 32'(bus2.ALUControl), 32'd0);
    @(negedge clk);
    #1;
    chk("w2_decode_state", 32'(bus2.State), 32'd1);
    @(negedge clk);
    #1;
    chk("w2_eor_state", 32'(bus2.State), 32'd10);
    chk("w2_eor_illegal", 32'(bus2.Illegal), 32'd1);
    @(negedge clk);
    #1;
    chk("w2_after_state", 32'(bus2.State), 32'd0);
    chk("w2_after_illegal", 32'(bus2.Illegal), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
